// File: rtl/insn_fetch_queue.sv
// Instruction fetch queue.
// Streams bytes from a synchronous program RAM, assembles BYTES_PER_INSN-byte instructions
// and buffers them in a FIFO_DEPTH-entry prefetch queue. The decoder consumes entries through
// a valid/ready handshake. A redirect flushes the queue and restarts fetch at a new PC.
module insn_fetch_queue #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned BYTES_PER_INSN = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned RESET_PC       = 92
) (
  input  logic                             clka,
  input  logic                             rst,
  output logic                             mem_en,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic [7:0]                       mem_dout,
  input  logic                             redirect_valid,
  input  logic [ADDR_W-1:0]                redirect_pc,
  output logic                             insn_valid,
  input  logic                             insn_ready,
  output logic [8*BYTES_PER_INSN-1:0]      insn_data,
  output logic [ADDR_W-1:0]                insn_pc,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int unsigned DataW = 8 * BYTES_PER_INSN;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned IdxW  = (BYTES_PER_INSN > 1) ? $clog2(BYTES_PER_INSN) : 1;

  localparam logic [IdxW-1:0]   LastIdx = IdxW'(BYTES_PER_INSN - 1);
  localparam logic [PtrW-1:0]   LastPtr = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW:0]     DepthW  = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

  typedef enum logic [0:0] {StFetch, StHold} state_e;

  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             pc_q, pc_d;
  logic [ADDR_W-1:0]             start_pc_q, start_pc_d;
  logic                          rd_pending_q, rd_pending_d;
  logic [IdxW-1:0]               iss_idx_q, iss_idx_d;
  logic [IdxW-1:0]               cap_idx_q, cap_idx_d;
  logic [BYTES_PER_INSN-1:0][7:0] asm_q, asm_d, asm_cap;

  logic [DataW-1:0]              fifo_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]             fifo_pc_q   [FIFO_DEPTH];
  logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]               count_q, count_d;

  logic                          issue, capture, cap_last, push, pop;
  logic                          next_is_first, inflight;
  logic [CntW:0]                 slots_used;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [IdxW-1:0] idx_inc(input logic [IdxW-1:0] i);
    return (i == LastIdx) ? '0 : i + 1'b1;
  endfunction

  assign issue    = (state_q == StFetch);
  assign capture  = rd_pending_q;
  assign cap_last = capture && (cap_idx_q == LastIdx);
  // A redirect overrides any push or pop on the same edge.
  assign push     = cap_last && !redirect_valid;
  assign pop      = insn_valid && insn_ready && !redirect_valid;

  // Assembly buffer with this cycle's RAM byte merged into its slot.
  always_comb begin
    asm_cap = asm_q;
    asm_cap[cap_idx_q] = mem_dout;
  end

  // Next-state logic for fetch FSM, assembly and FIFO pointers; redirect has top priority.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    start_pc_d    = start_pc_q;
    rd_pending_d  = rd_pending_q;
    iss_idx_d     = iss_idx_q;
    cap_idx_d     = cap_idx_q;
    asm_d         = asm_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    next_is_first = 1'b0;
    inflight      = 1'b0;
    slots_used    = '0;

    if (redirect_valid) begin
      state_d      = StFetch;
      pc_d         = redirect_pc;
      rd_pending_d = 1'b0;
      iss_idx_d    = '0;
      cap_idx_d    = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
    end else begin
      // Capture side: one byte per cycle, push when the last slot fills.
      if (capture) begin
        asm_d     = asm_cap;
        cap_idx_d = cap_last ? '0 : cap_idx_q + 1'b1;
      end

      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      // Issue side: the RAM samples pc_q this edge whenever mem_en is high.
      rd_pending_d = issue;
      if (issue) begin
        pc_d      = pc_q + 1'b1;
        iss_idx_d = idx_inc(iss_idx_q);
        if (iss_idx_q == '0) start_pc_d = pc_q;
      end

      // Only a new instruction's first byte needs a free slot; HOLD always sits at byte 0.
      next_is_first = issue ? (iss_idx_q == LastIdx) : 1'b1;
      inflight      = rd_pending_d || (cap_idx_d != '0);
      slots_used    = {1'b0, count_d} + {{CntW{1'b0}}, inflight};
      if (next_is_first) begin
        state_d = (slots_used < DepthW) ? StFetch : StHold;
      end else begin
        state_d = StFetch;
      end
    end
  end

  // Control and assembly state registers.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q      <= StFetch;
      pc_q         <= ResetPc;
      start_pc_q   <= '0;
      rd_pending_q <= 1'b0;
      iss_idx_q    <= '0;
      cap_idx_q    <= '0;
      asm_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      start_pc_q   <= start_pc_d;
      rd_pending_q <= rd_pending_d;
      iss_idx_q    <= iss_idx_d;
      cap_idx_q    <= cap_idx_d;
      asm_q        <= asm_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Queue storage; contents are only observable through a valid head, so no reset.
  always_ff @(posedge clka) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= asm_cap;
      fifo_pc_q[wr_ptr_q]   <= start_pc_q;
    end
  end

  // Outputs: head entry forced to zero while the queue is empty.
  always_comb begin
    mem_en     = (state_q == StFetch);
    mem_addr   = pc_q;
    fifo_count = count_q;
    insn_valid = (count_q != '0);
    insn_data  = insn_valid ? fifo_data_q[rd_ptr_q] : '0;
    insn_pc    = insn_valid ? fifo_pc_q[rd_ptr_q] : '0;
  end

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Scoreboard bench for insn_fetch_queue: a 16-bit-address instance for the main scenarios and an
// 8-bit-address instance for PC wrap. Expected head entries are queued by the stimulus and popped
// by monitors on every accepted handshake.
module tb_insn_fetch_queue;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] pc;
  } exp_t;

  logic clka = 1'b0;
  logic rst  = 1'b1;
  always #5 clka = ~clka;

  // 16-bit address instance
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn_data;
  logic [15:0] insn_pc;
  logic [2:0]  fifo_count;

  // 8-bit address instance
  logic        mem_en8;
  logic [7:0]  mem_addr8;
  logic [7:0]  mem_dout8;
  logic        redirect_valid8;
  logic [7:0]  redirect_pc8;
  logic        insn_valid8;
  logic        insn_ready8;
  logic [31:0] insn_data8;
  logic [7:0]  insn_pc8;
  logic [2:0]  fifo_count8;

  exp_t exp_q[$];
  exp_t exp8_q[$];
  exp_t mon_e, mon8_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  insn_fetch_queue #(
    .ADDR_W(16), .BYTES_PER_INSN(4), .FIFO_DEPTH(4), .RESET_PC(92)
  ) dut (
    .clka(clka), .rst(rst), .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .insn_valid(insn_valid),
    .insn_ready(insn_ready), .insn_data(insn_data), .insn_pc(insn_pc), .fifo_count(fifo_count)
  );

  insn_fetch_queue #(
    .ADDR_W(8), .BYTES_PER_INSN(4), .FIFO_DEPTH(4), .RESET_PC(92)
  ) dut8 (
    .clka(clka), .rst(rst), .mem_en(mem_en8), .mem_addr(mem_addr8), .mem_dout(mem_dout8),
    .redirect_valid(redirect_valid8), .redirect_pc(redirect_pc8), .insn_valid(insn_valid8),
    .insn_ready(insn_ready8), .insn_data(insn_data8), .insn_pc(insn_pc8),
    .fifo_count(fifo_count8)
  );

  // RAM contents: byte at address a is a[7:0]-91, so RAM[92..99] = 01..08.
  function automatic logic [7:0] ram_byte(input logic [15:0] a);
    return a[7:0] - 8'd91;
  endfunction

  always @(posedge clka) if (mem_en)  mem_dout  <= ram_byte(mem_addr);
  always @(posedge clka) if (mem_en8) mem_dout8 <= ram_byte({8'h00, mem_addr8});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clka);
      #1;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && exp8_q.size() == 0) break;
      tick(1);
    end
    check(name, 64'(exp_q.size() + exp8_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    insn_ready      = 1'b0;
    redirect_valid8 = 1'b0;
    redirect_pc8    = '0;
    insn_ready8     = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // Monitor for the 16-bit instance; a redirect cancels the handshake on that edge.
  initial forever begin
    @(negedge clka);
    if (insn_valid && insn_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %0d data 0x%h, required no transfer",
                 insn_pc, insn_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_data", 64'(insn_data), 64'(mon_e.data));
        check("pop_pc", 64'(insn_pc), 64'(mon_e.pc));
      end
    end
  end

  // Monitor for the 8-bit instance.
  initial forever begin
    @(negedge clka);
    if (insn_valid8 && insn_ready8 && !redirect_valid8) begin
      if (exp8_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop8: got pc %0d data 0x%h, required no transfer",
                 insn_pc8, insn_data8);
      end else begin
        mon8_e = exp8_q.pop_front();
        check("pop8_data", 64'(insn_data8), 64'(mon8_e.data));
        check("pop8_pc", 64'(insn_pc8), 64'(mon8_e.pc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, sampled while rst is held.
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    insn_ready      = 1'b0;
    redirect_valid8 = 1'b0;
    redirect_pc8    = '0;
    insn_ready8     = 1'b0;
    tick(2);
    check("rst_valid", 64'(insn_valid), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd1);
    check("rst_mem_addr", 64'(mem_addr), 64'd92);
    check("rst_data", 64'(insn_data), 64'd0);
    check("rst_pc", 64'(insn_pc), 64'd0);
    check("rst_mem_addr8", 64'(mem_addr8), 64'd92);

    // T1: streaming with decoder always ready; first valid after edge 5.
    do_reset();
    exp_q.push_back('{data: 32'h04030201, pc: 16'd92});
    exp_q.push_back('{data: 32'h08070605, pc: 16'd96});
    exp_q.push_back('{data: 32'h0C0B0A09, pc: 16'd100});
    exp_q.push_back('{data: 32'h100F0E0D, pc: 16'd104});
    insn_ready = 1'b1;
    tick(4);
    check("t1_valid_edge4", 64'(insn_valid), 64'd0);
    tick(1);
    check("t1_valid_edge5", 64'(insn_valid), 64'd1);
    check("t1_pc_edge5", 64'(insn_pc), 64'd92);
    check("t1_data_edge5", 64'(insn_data), 64'h04030201);
    tick(4);
    check("t1_pc_edge9", 64'(insn_pc), 64'd96);
    drain("t1_drain");
    insn_ready = 1'b0;

    // T2: backpressure fills the queue and parks fetch at 108.
    do_reset();
    tick(17);
    check("t2_count_full", 64'(fifo_count), 64'd4);
    check("t2_mem_en_hold", 64'(mem_en), 64'd0);
    check("t2_pc_hold", 64'(mem_addr), 64'd108);
    check("t2_head_data", 64'(insn_data), 64'h04030201);
    check("t2_head_pc", 64'(insn_pc), 64'd92);
    tick(3);
    check("t2_pc_still", 64'(mem_addr), 64'd108);
    check("t2_count_still", 64'(fifo_count), 64'd4);
    exp_q.push_back('{data: 32'h04030201, pc: 16'd92});
    insn_ready = 1'b1;
    tick(1);
    insn_ready = 1'b0;
    check("t2_count_after_pop", 64'(fifo_count), 64'd3);
    check("t2_mem_en_resume", 64'(mem_en), 64'd1);
    check("t2_pc_resume", 64'(mem_addr), 64'd108);
    check("t2_new_head", 64'(insn_pc), 64'd96);
    tick(5);
    check("t2_refill_count", 64'(fifo_count), 64'd4);
    check("t2_refill_pc", 64'(mem_addr), 64'd112);
    check("t2_refill_mem_en", 64'(mem_en), 64'd0);
    drain("t2_drain");

    // T3: redirect after two bytes of the second instruction have been captured.
    do_reset();
    tick(7);
    check("t3_pre_count", 64'(fifo_count), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'd200;
    tick(1);
    redirect_valid = 1'b0;
    check("t3_flush_count", 64'(fifo_count), 64'd0);
    check("t3_flush_valid", 64'(insn_valid), 64'd0);
    check("t3_pc_target", 64'(mem_addr), 64'd200);
    check("t3_mem_en", 64'(mem_en), 64'd1);
    exp_q.push_back('{data: 32'h706F6E6D, pc: 16'd200});
    exp_q.push_back('{data: 32'h74737271, pc: 16'd204});
    insn_ready = 1'b1;
    tick(4);
    check("t3_valid_early", 64'(insn_valid), 64'd0);
    tick(1);
    check("t3_valid_edge5", 64'(insn_valid), 64'd1);
    drain("t3_drain");
    insn_ready = 1'b0;

    // T4: redirect coinciding with a pop and a push.
    do_reset();
    tick(8);
    check("t4_pre_count", 64'(fifo_count), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'd300;
    insn_ready     = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    insn_ready     = 1'b0;
    check("t4_flush_count", 64'(fifo_count), 64'd0);
    check("t4_flush_valid", 64'(insn_valid), 64'd0);
    tick(4);
    check("t4_valid_early", 64'(insn_valid), 64'd0);
    tick(1);
    check("t4_count_new", 64'(fifo_count), 64'd1);
    check("t4_head_pc", 64'(insn_pc), 64'd300);
    exp_q.push_back('{data: 32'hD4D3D2D1, pc: 16'd300});
    insn_ready = 1'b1;
    drain("t4_drain");
    insn_ready = 1'b0;

    // T5: 8-bit PC, instruction straddling the wrap.
    do_reset();
    redirect_valid8 = 1'b1;
    redirect_pc8    = 8'd254;
    exp8_q.push_back('{data: 32'hA6A5A4A3, pc: 16'd254});
    exp8_q.push_back('{data: 32'hAAA9A8A7, pc: 16'd2});
    insn_ready8 = 1'b1;
    tick(1);
    redirect_valid8 = 1'b0;
    tick(4);
    check("t5_valid_early", 64'(insn_valid8), 64'd0);
    tick(1);
    check("t5_valid", 64'(insn_valid8), 64'd1);
    check("t5_pc", 64'(insn_pc8), 64'd254);
    drain("t5_drain");
    insn_ready8 = 1'b0;

    // T6: asynchronous reset mid-assembly with a nearly full queue, then refetch from 92.
    do_reset();
    tick(17);
    exp_q.push_back('{data: 32'h04030201, pc: 16'd92});
    insn_ready = 1'b1;
    tick(1);
    insn_ready = 1'b0;
    tick(3);
    check("t6_pre_count", 64'(fifo_count), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(insn_valid), 64'd0);
    check("t6_rst_count", 64'(fifo_count), 64'd0);
    check("t6_rst_mem_en", 64'(mem_en), 64'd1);
    check("t6_rst_mem_addr", 64'(mem_addr), 64'd92);
    check("t6_rst_data", 64'(insn_data), 64'd0);
    check("t6_rst_pc", 64'(insn_pc), 64'd0);
    tick(1);
    rst = 1'b0;
    exp_q.push_back('{data: 32'h04030201, pc: 16'd92});
    insn_ready = 1'b1;
    tick(1);
    check("t6_refetch_addr", 64'(mem_addr), 64'd93);
    tick(4);
    check("t6_refetch_valid", 64'(insn_valid), 64'd1);
    drain("t6_drain");
    insn_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
